mmio_bus_controller: RTL and testbench
======================================

// Module: mmio_bus_controller
// PURPOSE
//  Parametrised memory-map controller between the single-cycle core's data port and data RAM plus N MMIO peripherals.
//  Decodes RAM regions combinationally (zero latency).
//  MMIO slots go through a ready/timeout handshake FSM that stalls the core until the peripheral completes or times out.
//  Replaces fixed per-address decoding with a base/stride slot map of any size.
// PARAMETERS
//  DATA_WIDTH   32            data bus width
//  ADDR_WIDTH   32            address bus width
//  N_PERIPH     4             number of MMIO slots (>=1)
//  MMIO_BASE    'h10010024    address of slot 0
//  MMIO_STRIDE  4             byte distance between slots
//  STACK_LO     'h10011000    stack region lower bound, exclusive
//  STACK_HI     'h7FFFEFFC    stack region upper bound, inclusive
//  TIMEOUT      15            WAIT cycles before abort (>=1)
// PORTS
//  clk           in   1                    system clock, rising edge
//  rst_n         in   1                    asynchronous active-low reset
//  req_valid     in   1                    core load/store this cycle
//  req_we        in   1                    1=store, 0=load
//  req_addr      in   ADDR_WIDTH           byte address
//  req_wdata     in   DATA_WIDTH           store data
//  req_stall     out  1                    hold PC and request stable
//  rdata         out  DATA_WIDTH           load data to core
//  err           out  1                    1-cycle pulse: MMIO timeout
//  ram_we        out  1                    data RAM write enable
//  ram_addr_sel  out  1                    0=data region, 1=stack region
//  ram_rdata     in   DATA_WIDTH           data RAM read data
//  periph_sel    out  N_PERIPH             one-hot slot select, registered
//  periph_we     out  1                    write strobe, registered pulse
//  periph_wdata  out  DATA_WIDTH           registered store data
//  periph_ready  in   N_PERIPH             per-slot completion
//  periph_rdata  in   N_PERIPH*DATA_WIDTH  slot k at [k*DW +: DW]
// BEHAVIOUR
//  Decode, priority order:
//   - MMIO hit k: req_addr == MMIO_BASE + k*MMIO_STRIDE, k<N_PERIPH. Exact match only.
//   - Stack: STACK_LO < addr <= STACK_HI. ram_addr_sel=1.
//   - Else data region. ram_addr_sel=0.
//  RAM regions:
//   - ram_we = req_valid & req_we, combinational.
//   - rdata = ram_rdata, combinational.
//   - Never stall.
//  MMIO access: ram_we=0.
//  FSM states: IDLE, WAIT, DONE. Slot index and wait counter are registered.
//  IDLE: on req_valid & MMIO hit k:
//   - req_stall=1 combinationally.
//   - Next edge: latch k; periph_sel[k]=1; periph_we=req_we; periph_wdata=req_wdata; cnt=0; go WAIT.
//  WAIT:
//   - periph_sel held. periph_we only on the first WAIT cycle. req_stall=1. cnt++ each cycle.
//   - periph_ready[k]=1: capture periph_rdata[k] into rdata_q; go DONE.
//   - Else if cnt==TIMEOUT-1: rdata_q=0; err_q=1; go DONE.
//   - Ready and timeout in the same cycle: ready wins, err=0.
//   - periph_ready of unselected slots is ignored.
//  DONE:
//   - periph_sel=0. req_stall=0. rdata=rdata_q. err=err_q.
//   - Core retires the access this cycle. Next: IDLE, err_q=0.
//  Latency when ready arrives in the first WAIT cycle: 3 cycles, 2 of them stalled.
//  Reset (async, any state):
//   - state=IDLE; cnt=0; periph_sel=0; periph_we=0; periph_wdata=0; rdata_q=0; err=0.
//   - req_stall follows IDLE decode.
//   - In-flight transaction is dropped; no retry.
//  Counter width: $clog2(TIMEOUT+1). MMIO hit compare done at ADDR_WIDTH, no wrap.
//  req_valid=0: no enables, no stall; rdata = ram_rdata.
// TESTING
//  1. Store 'hA5 to 'h7FFFEFFC -> ram_we=1, ram_addr_sel=1, no stall. Same at 'h10011000 -> ram_addr_sel=0.
//  2. Load from slot 2 ('h1001002C), ready after 3 WAIT cycles with 'h55 -> stall 4 cycles, rdata='h55 in DONE, err=0.
//  3. Store 'h41 to slot 3 ('h10010030), ready after 1 cycle -> periph_we 1-cycle pulse, periph_wdata='h41, sel='b1000.
//  4. Load from slot 1, ready never -> 15 WAIT cycles, then DONE: rdata=0, err=1 pulse; FSM returns to IDLE.
//  5. rst_n low in the second WAIT cycle -> sel/we/stall clear at once; next MMIO request starts clean.
//  6. Address 'h10010026 (between slots) -> data region, no stall; periph_ready on an unselected slot -> ignored.

Source files
------------

// File: rtl/mmio_bus_controller.sv
// mmio_bus_controller: routes core data-port accesses to data RAM (stack or
// data region, zero latency) or to one of N_PERIPH MMIO slots laid out at
// MMIO_BASE + k*MMIO_STRIDE. MMIO accesses stall the core while a small
// IDLE/WAIT/DONE handshake waits for the slot's ready or a timeout.
`timescale 1ns/1ps
module mmio_bus_controller #(
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            N_PERIPH    = 4,
    parameter logic [ADDR_WIDTH-1:0]  MMIO_BASE   = 'h10010024,
    parameter int unsigned            MMIO_STRIDE = 4,
    parameter logic [ADDR_WIDTH-1:0]  STACK_LO    = 'h10011000,
    parameter logic [ADDR_WIDTH-1:0]  STACK_HI    = 'h7FFFEFFC,
    parameter int unsigned            TIMEOUT     = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    input  logic                           req_we,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [DATA_WIDTH-1:0]          req_wdata,
    output logic                           req_stall,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           err,
    output logic                           ram_we,
    output logic                           ram_addr_sel,
    input  logic [DATA_WIDTH-1:0]          ram_rdata,
    output logic [N_PERIPH-1:0]            periph_sel,
    output logic                           periph_we,
    output logic [DATA_WIDTH-1:0]          periph_wdata,
    input  logic [N_PERIPH-1:0]            periph_ready,
    input  logic [N_PERIPH*DATA_WIDTH-1:0] periph_rdata
);

    localparam int unsigned IDX_W = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    // Slot addresses are compared in a widened space so a slot whose address
    // would overflow ADDR_WIDTH can never alias a low address.
    localparam int unsigned EXT_W = ADDR_WIDTH + 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [IDX_W-1:0]        r_slot;
    logic [CNT_W-1:0]        r_cnt;
    logic [N_PERIPH-1:0]     r_sel;
    logic                    r_we;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata_q;
    logic                    r_err_q;

    logic [N_PERIPH-1:0]     w_hit_onehot;
    logic [IDX_W-1:0]        w_hit_idx;
    logic                    w_hit;
    logic                    w_stack;
    logic                    w_start;
    logic                    w_ready;
    logic                    w_timeout;
    logic [DATA_WIDTH-1:0]   w_slot_rdata;

    // Address decode: exact-match MMIO slot search, then stack window.
    always_comb begin
        w_hit_onehot = '0;
        w_hit_idx    = '0;
        for (int k = 0; k < N_PERIPH; k++) begin
            if ({{(EXT_W-ADDR_WIDTH){1'b0}}, req_addr} ==
                EXT_W'(MMIO_BASE) + EXT_W'(k) * EXT_W'(MMIO_STRIDE)) begin
                w_hit_onehot[k] = 1'b1;
                w_hit_idx       = IDX_W'(k);
            end
        end
    end

    assign w_hit        = |w_hit_onehot;
    assign w_stack      = (req_addr > STACK_LO) && (req_addr <= STACK_HI);
    assign w_start      = req_valid && w_hit;
    assign w_ready      = periph_ready[r_slot];
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_slot_rdata = periph_rdata[int'(r_slot)*DATA_WIDTH +: DATA_WIDTH];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a started MMIO access waits for ready or timeout,
    // then spends exactly one un-stalled cycle in DONE while the core retires.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next_state = S_WAIT;
            S_WAIT:  if (w_ready || w_timeout) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Transaction registers: slot, strobes, wait counter and the result that DONE presents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot    <= '0;
            r_cnt     <= '0;
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_rdata_q <= '0;
            r_err_q   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_slot  <= w_hit_idx;
                        r_sel   <= w_hit_onehot;
                        r_we    <= req_we;
                        r_wdata <= req_wdata;
                        r_cnt   <= '0;
                        r_err_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // The write strobe is a single pulse on the first WAIT cycle.
                    r_we  <= 1'b0;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_ready) begin
                        r_rdata_q <= w_slot_rdata;
                        r_err_q   <= 1'b0;
                        r_sel     <= '0;
                    end else if (w_timeout) begin
                        r_rdata_q <= '0;
                        r_err_q   <= 1'b1;
                        r_sel     <= '0;
                    end
                end
                S_DONE: begin
                    r_err_q <= 1'b0;
                end
                default: begin
                    r_sel <= '0;
                    r_we  <= 1'b0;
                end
            endcase
        end
    end

    // Core-facing and RAM-facing outputs; RAM regions pass straight through.
    always_comb begin
        req_stall    = 1'b0;
        rdata        = ram_rdata;
        err          = 1'b0;
        ram_we       = req_valid && req_we && !w_hit;
        ram_addr_sel = !w_hit && w_stack;
        case (r_state)
            S_IDLE: req_stall = w_start;
            S_WAIT: req_stall = 1'b1;
            S_DONE: begin
                rdata = r_rdata_q;
                err   = r_err_q;
            end
            default: req_stall = 1'b0;
        endcase
    end

    assign periph_sel   = r_sel;
    assign periph_we    = r_we;
    assign periph_wdata = r_wdata;

endmodule

// File: tb/tb_mmio_bus_controller.sv
// Testbench for mmio_bus_controller: directed scenarios plus randomized
// accesses checked against a transaction-level model of the memory map.
`timescale 1ns/1ps
module tb_mmio_bus_controller;

    localparam int          DW     = 32;
    localparam int          AW     = 32;
    localparam int          NP     = 4;
    localparam logic [31:0] BASE   = 32'h10010024;
    localparam int          STRIDE = 4;
    localparam logic [31:0] SLO    = 32'h10011000;
    localparam logic [31:0] SHI    = 32'h7FFFEFFC;
    localparam int          TMO    = 15;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_we;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic              req_stall;
    logic [DW-1:0]     rdata;
    logic              err;
    logic              ram_we;
    logic              ram_addr_sel;
    logic [DW-1:0]     ram_rdata;
    logic [NP-1:0]     periph_sel;
    logic              periph_we;
    logic [DW-1:0]     periph_wdata;
    logic [NP-1:0]     periph_ready;
    logic [NP*DW-1:0]  periph_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mmio_bus_controller #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_PERIPH(NP), .MMIO_BASE(BASE),
        .MMIO_STRIDE(STRIDE), .STACK_LO(SLO), .STACK_HI(SHI), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_stall(req_stall), .rdata(rdata), .err(err),
        .ram_we(ram_we), .ram_addr_sel(ram_addr_sel), .ram_rdata(ram_rdata),
        .periph_sel(periph_sel), .periph_we(periph_we), .periph_wdata(periph_wdata),
        .periph_ready(periph_ready), .periph_rdata(periph_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Memory-map model: slot index for an address, or -1.
    function automatic int slot_of(input logic [31:0] a);
        logic [63:0] a64;
        logic [63:0] s64;
        a64 = {32'd0, a};
        for (int k = 0; k < NP; k++) begin
            s64 = {32'd0, BASE} + 64'(k) * 64'(STRIDE);
            if (a64 == s64) return k;
        end
        return -1;
    endfunction

    function automatic logic in_stack(input logic [31:0] a);
        return (a > SLO) && (a <= SHI);
    endfunction

    task automatic rand_periph_rdata();
        for (int j = 0; j < NP; j++) periph_rdata[j*DW +: DW] = $urandom;
    endtask

    // One RAM access; never stalls and never touches the MMIO side.
    task automatic ram_access(input logic [31:0] a, input logic we, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        ram_rdata = $urandom; periph_ready = NP'($urandom); rand_periph_rdata();
        #1;
        check_val("ram.stall", req_stall, 0);
        check_val("ram.ram_we", ram_we, we);
        check_val("ram.addr_sel", ram_addr_sel, in_stack(a));
        check_val("ram.rdata", rdata, ram_rdata);
        check_val("ram.err", err, 0);
        check_val("ram.psel", periph_sel, 0);
        @(posedge clk); #1;
        check_val("ram.psel_next", periph_sel, 0);
        check_val("ram.pwe_next", periph_we, 0);
        check_val("ram.stall_next", req_stall, 0);
    endtask

    // One MMIO access to slot k; the slot raises ready in WAIT cycle 'delay'
    // (delay > TMO means never). Other slots see random ready noise under nz_mask.
    task automatic mmio_txn(input int k, input logic we, input logic [31:0] wd,
                            input logic [31:0] rd, input int delay, input logic [NP-1:0] nz_mask);
        logic        got_rdy;
        logic [NP-1:0] onehot;
        onehot  = NP'(1) << k;
        got_rdy = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = BASE + 32'(k * STRIDE); req_wdata = wd;
        ram_rdata = $urandom; rand_periph_rdata();
        periph_ready = NP'($urandom) & nz_mask & ~onehot;
        #1;
        check_val("idle.stall", req_stall, 1);
        check_val("idle.ram_we", ram_we, 0);
        check_val("idle.addr_sel", ram_addr_sel, 0);
        check_val("idle.psel", periph_sel, 0);
        check_val("idle.pwe", periph_we, 0);
        for (int w = 1; w <= TMO; w++) begin
            @(posedge clk); #1;
            rand_periph_rdata();
            periph_rdata[k*DW +: DW] = rd;
            periph_ready = NP'($urandom) & nz_mask & ~onehot;
            if (w == delay) periph_ready[k] = 1'b1;
            #1;
            check_val("wait.stall", req_stall, 1);
            check_val("wait.psel", periph_sel, onehot);
            check_val("wait.pwe", periph_we, (w == 1) ? we : 1'b0);
            check_val("wait.pwdata", periph_wdata, wd);
            check_val("wait.err", err, 0);
            check_val("wait.ram_we", ram_we, 0);
            if (w == delay) begin
                got_rdy = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        periph_ready = NP'($urandom);
        rand_periph_rdata();
        #1;
        check_val("done.stall", req_stall, 0);
        check_val("done.psel", periph_sel, 0);
        check_val("done.pwe", periph_we, 0);
        check_val("done.rdata", rdata, got_rdy ? rd : 32'd0);
        check_val("done.err", err, !got_rdy);
        @(posedge clk); #1;
        req_valid = 1'b0; periph_ready = '0; ram_rdata = $urandom;
        #1;
        check_val("after.err", err, 0);
        check_val("after.stall", req_stall, 0);
        check_val("after.psel", periph_sel, 0);
        check_val("after.rdata", rdata, ram_rdata);
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom;
        ram_rdata = $urandom; periph_ready = NP'($urandom);
        #1;
        check_val("nv.stall", req_stall, 0);
        check_val("nv.ram_we", ram_we, 0);
        check_val("nv.rdata", rdata, ram_rdata);
        check_val("nv.err", err, 0);
        @(posedge clk); #1;
        check_val("nv.psel", periph_sel, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] edges [10];
        edges = '{SLO, SLO + 1, SHI, SHI + 1, BASE - 1, BASE + 2, 32'h10010026,
                  BASE + 32'(NP * STRIDE), 32'h0, 32'hFFFFFFFC};

        // Reset state
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        ram_rdata = 32'hCAFE0001; periph_ready = '0; periph_rdata = '0;
        #2;
        check_val("rst.stall", req_stall, 0);
        check_val("rst.psel", periph_sel, 0);
        check_val("rst.pwe", periph_we, 0);
        check_val("rst.pwdata", periph_wdata, 0);
        check_val("rst.err", err, 0);
        check_val("rst.rdata", rdata, 32'hCAFE0001);
        req_valid = 1'b1; req_addr = BASE;
        #1;
        check_val("rst.stall_decode", req_stall, 1);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Region boundaries
        ram_access(SHI, 1'b1, 32'hA5);
        ram_access(SLO, 1'b1, 32'hA5);
        ram_access(SLO + 1, 1'b0, 32'h0);
        ram_access(SHI + 1, 1'b1, 32'h1);
        ram_access(32'h10010026, 1'b1, 32'h77);

        // Slot 2 load, ready in third WAIT cycle
        mmio_txn(2, 1'b0, 32'h0, 32'h55, 3, '0);
        // Slot 3 store, ready in first WAIT cycle
        mmio_txn(3, 1'b1, 32'h41, 32'h0, 1, '0);
        // Slot 1 load, never ready
        mmio_txn(1, 1'b0, 32'h0, 32'hDEAD, TMO + 1, '0);
        // Ready coincides with the last WAIT cycle: ready wins
        mmio_txn(0, 1'b0, 32'h0, 32'h1234, TMO, '0);
        // Other slots constantly ready must not complete slot 0
        mmio_txn(0, 1'b1, 32'h99, 32'h5A5A, 6, '1);
        mmio_txn(2, 1'b0, 32'h0, 32'h0, TMO + 3, '1);

        // Reset during the second WAIT cycle
        req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'(1 * STRIDE); req_wdata = 32'hBEEF;
        periph_ready = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("rstw.psel_before", periph_sel, 4'b0010);
        rst_n = 1'b0; req_valid = 1'b0;
        #1;
        check_val("rstw.psel", periph_sel, 0);
        check_val("rstw.pwe", periph_we, 0);
        check_val("rstw.stall", req_stall, 0);
        check_val("rstw.pwdata", periph_wdata, 0);
        check_val("rstw.err", err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mmio_txn(1, 1'b0, 32'h0, 32'h3C3C, 2, '0);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: mmio_txn($urandom_range(0, NP - 1), 1'($urandom_range(0, 1)), $urandom,
                                     $urandom, $urandom_range(1, TMO + 2), NP'($urandom));
                4: idle_cycle();
                default: begin
                    if ($urandom_range(0, 1) == 0) a = edges[$urandom_range(0, 9)];
                    else a = $urandom;
                    if (slot_of(a) >= 0)
                        mmio_txn(slot_of(a), 1'($urandom_range(0, 1)), $urandom, $urandom,
                                 $urandom_range(1, TMO + 2), NP'($urandom));
                    else
                        ram_access(a, 1'($urandom_range(0, 1)), $urandom);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
